ethernet_tx: RTL and testbench
==============================

// Module: ethernet_tx
// PURPOSE
//  MII transmit MAC: accepts frame bytes (DA..payload, no FCS) on a valid/ready byte stream, emits
//  preamble+SFD, data nibbles (low nibble first), zero pad to MIN_FRAME bytes, CRC-32 FCS, then
//  enforces the inter-frame gap. Transmit-side counterpart of ethernet_rx; drives the PHY TX nibble bus.
// PARAMETERS
//  MIN_FRAME  60  minimum data+pad bytes before FCS (pad with 0x00 if frame is shorter)
//  IFG_BYTES  12  inter-frame gap in byte times (2*IFG_BYTES clocks with tx_en=0)
// PORTS
//  clk      in   1  nibble clock; all logic on rising edge
//  rst      in   1  synchronous, active-high reset
//  s_data   in   8  frame byte
//  s_valid  in   1  s_data valid
//  s_last   in   1  qualifies final byte of frame (with s_valid)
//  s_ready  out  1  byte accepted on clk edge where s_valid&&s_ready
//  txd      out  4  MII transmit nibble
//  tx_en    out  1  MII transmit enable
//  tx_er    out  1  MII transmit error (abort marker)
//  busy     out  1  high in every state except IDLE
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high. All outputs registered.
//  - Reset: txd=0, tx_en=0, tx_er=0, s_ready=0, busy=0, state=IDLE, counters/CRC cleared. Reset mid-frame
//    drops tx_en next edge; no IFG enforced after reset; new frame may start first cycle after rst=0.
//  - States: IDLE -> PREAMBLE -> DATA -> PAD -> FCS -> IFG -> IDLE; DATA -> ABORT -> DROP -> IFG.
//  - IDLE: s_ready=0. s_valid=1 at cycle T -> PREAMBLE; txd=0x5,tx_en=1 from T+1.
//  - PREAMBLE: 15 nibbles 0x5 (T+1..T+15), then SFD nibble 0xD at T+16. s_ready=1 during T+16 only
//    (first byte captured at that edge); low nibble of byte 0 on txd at T+17.
//  - DATA: per byte, low nibble cycle k, high nibble k+1; s_ready=1 during k+1 to fetch next byte
//    (one pulse every 2 clocks, never on consecutive cycles). s_ready=0 after s_last byte accepted.
//  - Underrun: s_ready=1 and s_valid=0 -> ABORT: one cycle txd=0,tx_en=1,tx_er=1; then DROP: tx_en=0,
//    s_ready=1 continuously until handshake with s_last=1; then IFG. No FCS sent for aborted frame.
//  - Byte counter: 7-bit, counts data+pad bytes, saturates at MIN_FRAME. After last data high nibble:
//    count<MIN_FRAME -> PAD (0x0 nibbles until count==MIN_FRAME), else straight to FCS.
//  - CRC-32: reflected poly 0xEDB88320, init 0xFFFFFFFF, updated per nibble over data+pad only;
//    FCS = ~crc, sent as 8 nibbles LSB-nibble first (crc[3:0] first). tx_en=1 through last FCS nibble.
//  - IFG: tx_en=0,txd=0 for exactly 2*IFG_BYTES clocks (24) after last FCS nibble; s_ready=0; a pending
//    s_valid is held off and starts PREAMBLE on the first cycle after IFG -> IDLE (IDLE lasts 1 cycle min).
//  - Total tx_en cycles for N-byte frame (no abort): 16 + 2*max(N,MIN_FRAME) + 8.
//  - s_last on first byte legal (1-byte frame). s_data/s_last ignored when s_ready=0.
//  - tx_er=0 except ABORT cycle. txd=0 whenever tx_en=0.
// TESTING
//  1-byte frame 0xAB,s_last -> 15x 0x5, 0xD, B, A, 118x 0x0, 8 FCS nibbles = model CRC; tx_en high 144 clk.
//  64 bytes 0x00..0x3F -> no pad; tx_en high 152 clk; 64 s_ready pulses, 2 clk apart; FCS matches model.
//  Exactly 60 bytes -> no PAD state entered; tx_en high 144 clk.
//  Two frames, s_valid held high -> tx_en low exactly 24 clk between frames, 2nd preamble then starts.
//  s_valid dropped at byte 10 of 20 -> 1 clk tx_en=1,tx_er=1,txd=0; then tx_en=0, remaining bytes
//  drained with s_ready=1 to s_last; no FCS; 24-clk IFG.
//  rst pulsed 1 clk during FCS -> tx_en=0,busy=0 next edge; new frame preamble 1 clk after rst=0.

Source files
------------

// File: rtl/ethernet_tx.sv
// ethernet_tx: MII transmit MAC (preamble/SFD, nibble data, zero pad, CRC-32 FCS, inter-frame gap)
module ethernet_tx #(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [3:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRE   = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAD   = 3'd3;
  localparam logic [2:0] FCS   = 3'd4;
  localparam logic [2:0] IFG   = 3'd5;
  localparam logic [2:0] ABORT = 3'd6;
  localparam logic [2:0] DROP  = 3'd7;
  localparam logic [6:0] MIN_B = 7'(MIN_FRAME);
  // IDLE always spends one cycle with tx_en low, so IFG state covers the rest of the gap
  localparam logic [7:0] IFG_LAST = 8'(2 * IFG_BYTES - 2);
  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  bcnt_q, bcnt_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic [3:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d, tx_er_q, tx_er_d, s_ready_q, s_ready_d, busy_q, busy_d;
  logic        fetch, go_fcs, pad;
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c ^ {28'd0, n};
    for (int i = 0; i < 4; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 8'd1;
    bcnt_d    = bcnt_q;
    crc_d     = crc_q;
    byte_d    = byte_q;
    last_d    = last_q;
    txd_d     = 4'h0;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    s_ready_d = 1'b0;
    fetch     = 1'b0;
    go_fcs    = 1'b0;
    pad       = 1'b0;
    case (state_q)
      IDLE: if (s_valid) begin
        state_d = PRE;
        cnt_d   = 8'd0;
        bcnt_d  = 7'd0;
        crc_d   = '1;
        tx_en_d = 1'b1;
        txd_d   = 4'h5;
      end
      PRE: begin
        tx_en_d   = 1'b1;
        txd_d     = cnt_q == 8'd14 ? 4'hD : 4'h5;
        s_ready_d = cnt_q == 8'd14;
        fetch     = cnt_q == 8'd15;
      end
      DATA: if (cnt_q == 8'd0) begin
        tx_en_d   = 1'b1;
        txd_d     = byte_q[7:4];
        crc_d     = crc_nib(crc_q, byte_q[7:4]);
        s_ready_d = !last_q;
      end else if (last_q) begin
        go_fcs = bcnt_q >= MIN_B;
        pad    = bcnt_q < MIN_B;
      end else fetch = 1'b1;
      PAD: if (cnt_q == 8'd0) begin
        tx_en_d = 1'b1;
        crc_d   = crc_nib(crc_q, 4'h0);
      end else begin
        go_fcs = bcnt_q == MIN_B;
        pad    = bcnt_q != MIN_B;
      end
      FCS: begin
        tx_en_d = cnt_q != 8'd7;
        txd_d   = cnt_q != 8'd7 ? ~crc_q[3:0] : 4'h0;
        crc_d   = crc_q >> 4;
        state_d = cnt_q == 8'd7 ? IFG : FCS;
        cnt_d   = cnt_q == 8'd7 ? 8'd0 : cnt_q + 8'd1;
      end
      IFG: state_d = cnt_q == IFG_LAST ? IDLE : IFG;
      ABORT: begin
        state_d   = DROP;
        s_ready_d = 1'b1;
      end
      DROP: if (s_valid && s_last) begin
        state_d = IFG;
        cnt_d   = 8'd0;
      end else s_ready_d = 1'b1;
      default: state_d = IDLE;
    endcase
    // s_ready was high this cycle: take the next byte, or abort on underrun
    if (fetch) begin
      cnt_d   = 8'd0;
      tx_en_d = 1'b1;
      if (s_valid) begin
        state_d = DATA;
        byte_d  = s_data;
        last_d  = s_last;
        bcnt_d  = bcnt_q == MIN_B ? bcnt_q : bcnt_q + 7'd1;
        txd_d   = s_data[3:0];
        crc_d   = crc_nib(crc_q, s_data[3:0]);
      end else begin
        state_d = ABORT;
        tx_er_d = 1'b1;
        txd_d   = 4'h0;
      end
    end
    if (pad) begin
      state_d = PAD;
      cnt_d   = 8'd0;
      tx_en_d = 1'b1;
      bcnt_d  = bcnt_q + 7'd1;
      crc_d   = crc_nib(crc_q, 4'h0);
    end
    if (go_fcs) begin
      state_d = FCS;
      cnt_d   = 8'd0;
      tx_en_d = 1'b1;
      txd_d   = ~crc_q[3:0];
      crc_d   = crc_q >> 4;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      crc_q     <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      txd_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      crc_q     <= crc_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      txd_q     <= txd_d;
      tx_en_q   <= tx_en_d;
      tx_er_q   <= tx_er_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
    end
  end
  assign txd     = txd_q;
  assign tx_en   = tx_en_q;
  assign tx_er   = tx_er_q;
  assign s_ready = s_ready_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_ethernet_tx.sv
// tb_ethernet_tx: directed self-checking bench for ethernet_tx
module tb_ethernet_tx;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] s_data = '0;
  logic s_valid = 1'b0, s_last = 1'b0;
  logic s_ready, tx_en, tx_er, busy;
  logic [3:0] txd;
  int total = 0, bad = 0;
  logic [7:0] db[256];
  logic dl[256];
  logic [3:0] l_txd[$];
  logic l_en[$], l_er[$], l_rdy[$], l_val[$], l_busy[$];
  logic [3:0] exp_q[$];
  bit mon_on = 1'b0;
  ethernet_tx dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .txd(txd), .tx_en(tx_en), .tx_er(tx_er), .busy(busy)
  );
  always #5 clk = ~clk;
  // entry k: outputs during cycle k, plus the inputs seen at the edge ending cycle k
  always @(negedge clk) begin
    #1;
    if (mon_on) begin
      l_txd.push_back(txd);
      l_en.push_back(tx_en);
      l_er.push_back(tx_er);
      l_rdy.push_back(s_ready);
      l_val.push_back(s_valid);
      l_busy.push_back(busy);
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic clear_log();
    l_txd = {}; l_en = {}; l_er = {}; l_rdy = {}; l_val = {}; l_busy = {};
  endtask
  task automatic drive(input int n, input int gap_at, output int got);
    int idx = 0, gapc = 0, cyc = 0;
    bit hsp = 1'b0;
    while (idx < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (hsp) idx++;
      if (idx < n && idx == gap_at && gapc < 3) begin
        s_valid = 1'b0;
        gapc++;
      end else if (idx < n) begin
        s_valid = 1'b1;
        s_data  = db[idx];
        s_last  = dl[idx];
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      hsp = s_valid && s_ready;
    end
    got = idx;
  endtask
  task automatic wait_idle(output bit ok);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((busy || tx_en) && c < 3000);
    repeat (2) @(negedge clk);
    ok = c < 3000;
  endtask
  task automatic build_exp(input int base, input int n);
    logic [31:0] c, f;
    logic [7:0] b;
    int m;
    exp_q = {};
    repeat (15) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    c = 32'hFFFFFFFF;
    m = n < 60 ? 60 : n;
    for (int i = 0; i < m; i++) begin
      b = i < n ? db[base+i] : 8'h00;
      exp_q.push_back(b[3:0]);
      exp_q.push_back(b[7:4]);
      c = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    f = ~c;
    for (int k = 0; k < 8; k++) exp_q.push_back(f[4*k+:4]);
  endtask
  function automatic int first_en(input int from);
    for (int i = from; i < l_en.size(); i++) if (l_en[i] === 1'b1) return i;
    return -1;
  endfunction
  function automatic int run_len(input int s);
    int n = 0;
    if (s < 0) return -1;
    while (s + n < l_en.size() && l_en[s+n] === 1'b1) n++;
    return n;
  endfunction
  function automatic int cmp_stream(input int s, input int lim);
    if (s < 0) return 0;
    for (int i = 0; i < lim; i++) begin
      if (s + i >= l_txd.size()) return i;
      if (l_txd[s+i] !== exp_q[i] || l_en[s+i] !== 1'b1) return i;
    end
    return -1;
  endfunction
  function automatic int noisy_idle();
    int n = 0;
    for (int i = 0; i < l_en.size(); i++) if ((l_en[i] !== 1'b1 && l_txd[i] !== 4'h0) || l_er[i] !== 1'b0) n++;
    return n;
  endfunction
  function automatic logic [3:0] got_at(input int s, input int i);
    return (s >= 0 && s + i < l_txd.size()) ? l_txd[s+i] : 4'hx;
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (txd !== 4'h0) begin bad++; $display("FAIL reset_txd got=%h exp=0", txd); end
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en got=%b exp=0", tx_en); end
    total++; if (tx_er !== 1'b0) begin bad++; $display("FAIL reset_tx_er got=%b exp=0", tx_er); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_one_byte();
    int got, s, len, mm;
    bit ok;
    clear_log();
    mon_on = 1'b1;
    db[0] = 8'hAB; dl[0] = 1'b1;
    drive(1, -1, got);
    wait_idle(ok);
    mon_on = 1'b0;
    build_exp(0, 1);
    s = first_en(0);
    len = run_len(s);
    total++; if (!ok || got != 1) begin bad++; $display("FAIL one_byte_done got=%0d ok=%0b exp=1", got, ok); end
    total++; if (len != 144) begin bad++; $display("FAIL one_byte_len got=%0d exp=144", len); end
    mm = cmp_stream(s, exp_q.size());
    total++; if (mm != -1) begin bad++; $display("FAIL one_byte_nibble idx=%0d got=%h exp=%h", mm, got_at(s, mm), exp_q[mm]); end
    mm = noisy_idle();
    total++; if (mm != 0) begin bad++; $display("FAIL one_byte_quiet got=%0d exp=0", mm); end
  endtask
  task automatic test_64();
    int got, s, len, mm, np, prev, badsp;
    bit ok;
    clear_log();
    mon_on = 1'b1;
    for (int i = 0; i < 64; i++) begin db[i] = 8'(i); dl[i] = (i == 63); end
    drive(64, -1, got);
    wait_idle(ok);
    mon_on = 1'b0;
    build_exp(0, 64);
    s = first_en(0);
    len = run_len(s);
    total++; if (len != 152) begin bad++; $display("FAIL f64_len got=%0d exp=152", len); end
    mm = cmp_stream(s, exp_q.size());
    total++; if (mm != -1) begin bad++; $display("FAIL f64_nibble idx=%0d got=%h exp=%h", mm, got_at(s, mm), exp_q[mm]); end
    np = 0; prev = -1; badsp = 0;
    for (int i = 0; i < l_rdy.size(); i++) if (l_rdy[i] === 1'b1) begin
      if (prev >= 0 && i - prev != 2) badsp++;
      prev = i;
      np++;
    end
    total++; if (np != 64) begin bad++; $display("FAIL f64_ready_pulses got=%0d exp=64", np); end
    total++; if (badsp != 0) begin bad++; $display("FAIL f64_ready_spacing got=%0d exp=0", badsp); end
    mm = noisy_idle();
    total++; if (mm != 0) begin bad++; $display("FAIL f64_quiet got=%0d exp=0", mm); end
  endtask
  task automatic test_60();
    int got, s, len, mm;
    bit ok;
    clear_log();
    mon_on = 1'b1;
    for (int i = 0; i < 60; i++) begin db[i] = 8'(8'hC3 ^ 8'(i * 7)); dl[i] = (i == 59); end
    drive(60, -1, got);
    wait_idle(ok);
    mon_on = 1'b0;
    build_exp(0, 60);
    s = first_en(0);
    len = run_len(s);
    total++; if (len != 144) begin bad++; $display("FAIL f60_len got=%0d exp=144", len); end
    mm = cmp_stream(s, exp_q.size());
    total++; if (mm != -1) begin bad++; $display("FAIL f60_nibble idx=%0d got=%h exp=%h", mm, got_at(s, mm), exp_q[mm]); end
  endtask
  task automatic test_back_to_back();
    int got, s1, l1, s2, l2, mm;
    bit ok;
    clear_log();
    mon_on = 1'b1;
    db[0] = 8'h11; dl[0] = 1'b0; db[1] = 8'h22; dl[1] = 1'b1;
    db[2] = 8'h33; dl[2] = 1'b0; db[3] = 8'h44; dl[3] = 1'b1;
    drive(4, -1, got);
    wait_idle(ok);
    mon_on = 1'b0;
    s1 = first_en(0);
    l1 = run_len(s1);
    s2 = s1 < 0 ? -1 : first_en(s1 + l1);
    l2 = run_len(s2);
    total++; if (l1 != 144) begin bad++; $display("FAIL b2b_len1 got=%0d exp=144", l1); end
    total++; if (s2 < 0 || s2 - (s1 + l1) != 24) begin bad++; $display("FAIL b2b_gap got=%0d exp=24", s2 - (s1 + l1)); end
    total++; if (l2 != 144) begin bad++; $display("FAIL b2b_len2 got=%0d exp=144", l2); end
    build_exp(2, 2);
    mm = cmp_stream(s2, exp_q.size());
    total++; if (mm != -1) begin bad++; $display("FAIL b2b_nibble2 idx=%0d got=%h exp=%h", mm, got_at(s2, mm), exp_q[mm]); end
  endtask
  task automatic test_abort();
    int got, s, len, ner, h, mm, gapbad, rdybad;
    bit ok;
    clear_log();
    mon_on = 1'b1;
    for (int i = 0; i < 20; i++) begin db[i] = 8'(8'h40 + i); dl[i] = (i == 19); end
    drive(20, 10, got);
    wait_idle(ok);
    mon_on = 1'b0;
    build_exp(0, 20);
    s = first_en(0);
    len = run_len(s);
    ner = 0;
    for (int i = 0; i < l_er.size(); i++) if (l_er[i] === 1'b1) ner++;
    h = -1;
    for (int i = 0; i < l_rdy.size(); i++) if (l_rdy[i] === 1'b1 && l_val[i] === 1'b1) h = i;
    total++; if (got != 20) begin bad++; $display("FAIL abort_drained got=%0d exp=20", got); end
    total++; if (len != 37) begin bad++; $display("FAIL abort_en_len got=%0d exp=37", len); end
    total++; if (ner != 1) begin bad++; $display("FAIL abort_er_count got=%0d exp=1", ner); end
    total++; if (s < 0 || l_er[s+36] !== 1'b1 || l_txd[s+36] !== 4'h0) begin bad++; $display("FAIL abort_er_cycle got_er=%b got_txd=%h exp=1/0", s < 0 ? 1'bx : l_er[s+36], got_at(s, 36)); end
    mm = cmp_stream(s, 36);
    total++; if (mm != -1) begin bad++; $display("FAIL abort_prefix idx=%0d got=%h exp=%h", mm, got_at(s, mm), exp_q[mm]); end
    rdybad = 0;
    if (s >= 0 && h > s + 37) for (int i = s + 37; i <= h; i++) if (l_rdy[i] !== 1'b1 || l_en[i] !== 1'b0) rdybad++;
    total++; if (h <= s + 37 || rdybad != 0) begin bad++; $display("FAIL abort_drop_ready got=%0d exp=0 last_hs=%0d", rdybad, h); end
    gapbad = 0;
    if (h >= 0 && h + 24 < l_en.size()) begin
      for (int i = h + 1; i <= h + 24; i++) if (l_en[i] !== 1'b0) gapbad++;
      if (l_busy[h+23] !== 1'b1 || l_busy[h+24] !== 1'b0) gapbad++;
    end else gapbad = 99;
    total++; if (gapbad != 0) begin bad++; $display("FAIL abort_ifg got=%0d exp=0", gapbad); end
  endtask
  task automatic test_rst_fcs();
    int got, c, ne, len;
    bit ok;
    clear_log();
    mon_on = 1'b1;
    db[0] = 8'h5A; dl[0] = 1'b1;
    drive(1, -1, got);
    c = 0;
    do begin
      @(negedge clk);
      #2;
      ne = 0;
      foreach (l_en[i]) if (l_en[i] === 1'b1) ne++;
      c++;
    end while (ne < 139 && c < 3000);
    total++; if (ne < 139) begin bad++; $display("FAIL rst_reach_fcs got=%0d exp=139", ne); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL rst_fcs_tx_en got=%b exp=0", tx_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_fcs_busy got=%b exp=0", busy); end
    rst = 1'b0;
    s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
    @(negedge clk);
    total++; if (tx_en !== 1'b1 || txd !== 4'h5) begin bad++; $display("FAIL rst_restart got=%b/%h exp=1/5", tx_en, txd); end
    db[0] = 8'h77;
    drive(1, -1, got);
    wait_idle(ok);
    mon_on = 1'b0;
    len = 0;
    for (int i = l_en.size() - 1; i >= 0; i--) begin
      if (l_en[i] === 1'b1) len++;
      else if (len > 0) break;
    end
    total++; if (len != 144) begin bad++; $display("FAIL rst_new_frame_len got=%0d exp=144", len); end
  endtask
  initial begin
    test_reset();
    test_one_byte();
    test_64();
    test_60();
    test_back_to_back();
    test_abort();
    test_rst_fcs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
